video_histogram: RTL and testbench
==================================

# video_histogram

Parametrised frame histogram engine on the luma path, the successor to the fixed 8-bin counter in the edge-detect top. Once armed, it captures one full video frame of pixel values into 2^BIN_BITS saturating counters. It then holds the result for a four-phase register-bus readout. It re-clears its memory on every arm and after reset, and it forwards read-modify-write hazards so back-to-back identical pixels are counted exactly.

## Interface
- DATA_WIDTH, 8: pixel width; bin index = top BIN_BITS bits of pixel_i.
- BIN_BITS, 3: log2 of bin count (1..DATA_WIDTH).
- CNT_WIDTH, 32: counter width; counters saturate at all-ones.
- VS_POL, 1: 1 = vs_i active-high, 0 = active-low.
- SYNC_STAGES, 2: synchronizer depth for rd_req_i (≥2).
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-low reset.
- pixel_i  in  DATA_WIDTH  pixel value, qualified by dv_i.
- dv_i  in  1  pixel valid.
- vs_i  in  1  vertical sync, polarity per VS_POL.
- arm_i  in  1  one-cycle pulse: clear memory, then capture the next frame.
- rd_req_i  in  1  asynchronous four-phase read request.
- rd_addr_i  in  BIN_BITS  bin to read; stable while rd_req_i is high.
- rd_ack_o  out  1  read acknowledge; reset 0.
- rd_data_o  out  CNT_WIDTH  bin count; reset 0.
- done_o  out  1  a captured frame is held; reset 0.
- busy_o  out  1  in CLEAR, ARMED or COUNT; reset 1.
- sat_o  out  1  a counter saturated in the held frame; reset 0.
- frame_pix_o  out  CNT_WIDTH  valid pixels in the held frame (saturating); reset 0.

## Operation
- vs is normalised per VS_POL. The frame boundary is the cycle where the normalised vs rises.
- States:
  - CLEAR: write 0 to bin clr_addr; clr_addr increments; after bin 2^BIN_BITS-1 go to ARMED if armed_pend, else IDLE.
  - IDLE: arm_i → CLEAR with armed_pend=1.
  - ARMED: ignore pixels; on a frame boundary → COUNT, and clear frame_pix_o and sat_o.
  - COUNT: each dv_i increments bin[pixel_i[DATA_WIDTH-1 -: BIN_BITS]] and frame_pix_o. The next frame boundary → DRAIN.
  - DRAIN: 2 cycles for the pipeline to empty, then → DONE with done_o=1.
  - DONE: serves reads; arm_i → CLEAR, done_o=0.
- Reset enters CLEAR with clr_addr=0 and armed_pend=0.
- arm_i is ignored in ARMED, COUNT and DRAIN. arm_i in CLEAR sets armed_pend.
- Counting uses a 2-stage RMW pipeline: S1 reads the RAM, S2 adds 1 and writes.
  - If S2 writes the bin that S1 is reading, S1 takes S2's new value, not the RAM value.
  - N consecutive identical pixels therefore give exactly N.
- Saturation: a counter at all-ones stays there and sets sat_o. frame_pix_o saturates the same way and does not set sat_o.
- Pixels present on the frame-boundary cycle belong to the new frame. In COUNT→DRAIN they are dropped.
- Read handshake:
  - rd_req_i passes through a SYNC_STAGES-flop synchronizer.
  - A rising edge of the synchronized request samples rd_addr_i.
  - rd_data_o updates one cycle later, and rd_ack_o rises in the same cycle.
  - rd_ack_o falls one cycle after the synchronized request falls.
  - In any state other than DONE, the read returns rd_data_o=0 and is still acknowledged, without touching the RAM.
- Reset mid-operation: all state is lost and the block restarts in CLEAR.

## Timing
- A pixel at cycle t is visible in the RAM at t+2. Forwarding covers t+1.
- Arm-to-ARMED latency: 1 + 2^BIN_BITS cycles.
- Read latency, from rd_req_i rising to rd_ack_o rising: SYNC_STAGES + 2 cycles.
- frame_pix_o and done_o update on the DRAIN→DONE cycle.
- All outputs are registered.

## Structure
- Package hist_pkg holds the state encoding (CLEAR, IDLE, ARMED, COUNT, DRAIN, DONE) and the VS polarity helper constant.
- Sub-module hist_ram: simple dual-port RAM, 2^BIN_BITS × CNT_WIDTH, one write port, one read port with 1-cycle registered read, no reset.

## Test plan
- Reset, then poll: busy_o=1 for 8 cycles (BIN_BITS=3), then IDLE. Reading bin 5 returns 0 with an ack.
- Arm, then one frame of 10 pixels 0xE0 back-to-back, 3 pixels 0x00 and 1 pixel 0x20 → bin7=10, bin0=3, bin1=1, frame_pix_o=14, sat_o=0.
- Alternate 0x40/0x40/0x60/0x40 each cycle for 100 cycles → bin2=75, bin3=25 (forwarding check).
- CNT_WIDTH=4, 20 pixels of 0xFF → bin7=15, sat_o=1, frame_pix_o=15.
- Read during COUNT returns 0 and acks. In DONE, the read handshake completes in SYNC_STAGES+2 cycles, and rd_ack_o falls after the request drops.
- Assert reset (rst=0) mid-COUNT → all outputs at reset values, busy_o=1. A new arm plus frame gives counts with no residue from the aborted frame.

Source files
------------

// File: rtl/hist_pkg.sv
// Shared encodings for the frame histogram engine: FSM states and the
// vertical-sync polarity reference used to normalise vs_i.
package hist_pkg;

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_ARMED,
    ST_COUNT,
    ST_DRAIN,
    ST_DONE
  } hist_state_e;

  // VS_POL value meaning "vs_i is already active-high".
  localparam bit VS_ACTIVE_HIGH = 1'b1;

endpackage

// File: rtl/hist_ram.sv
// Simple dual-port bin memory: one write port, one registered read port.
// Read-during-write to the same address returns the old contents.
module hist_ram #(
  parameter int AW = 3,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/video_histogram.sv
// Frame histogram engine: clears, captures one frame into saturating bins,
// then holds the result for an asynchronous four-phase readout.
module video_histogram
  import hist_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int BIN_BITS    = 3,
  parameter int CNT_WIDTH   = 32,
  parameter int VS_POL      = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] pixel_i,
  input  logic                  dv_i,
  input  logic                  vs_i,
  input  logic                  arm_i,
  input  logic                  rd_req_i,
  input  logic [BIN_BITS-1:0]   rd_addr_i,
  output logic                  rd_ack_o,
  output logic [CNT_WIDTH-1:0]  rd_data_o,
  output logic                  done_o,
  output logic                  busy_o,
  output logic                  sat_o,
  output logic [CNT_WIDTH-1:0]  frame_pix_o
);

  localparam bit VS_ACT = (VS_POL != 0) ? VS_ACTIVE_HIGH : ~VS_ACTIVE_HIGH;

  typedef struct packed {
    logic                 vld;
    logic [BIN_BITS-1:0]  addr;
    logic [CNT_WIDTH-1:0] data;
  } wr_stage_t;

  hist_state_e          state, state_nxt;
  logic [BIN_BITS-1:0]  clr_addr, clr_addr_nxt;
  logic                 armed_pend, armed_pend_nxt;
  logic                 drain_cnt, drain_cnt_nxt;

  logic                 vs_n, vs_q, boundary;
  logic [BIN_BITS-1:0]  pix_bin;
  logic                 frame_start, cnt_issue;
  logic                 pix_unused;

  logic                 s1_vld;
  logic [BIN_BITS-1:0]  s1_addr;
  wr_stage_t            s2;
  logic [CNT_WIDTH-1:0] ram_rdata, operand, incr;
  logic                 op_full;

  logic                 ram_we;
  logic [BIN_BITS-1:0]  ram_waddr, ram_raddr;
  logic [CNT_WIDTH-1:0] ram_wdata;

  logic [CNT_WIDTH-1:0] pix_cnt;
  logic                 sat_acc;

  logic [SYNC_STAGES-1:0] req_sync;
  logic                   req_s, req_q, req_rise;
  logic                   rd_pend, rd_pend_done;

  assign vs_n        = (vs_i == VS_ACT);
  assign boundary    = vs_n & ~vs_q;
  assign pix_bin     = pixel_i[DATA_WIDTH-1 -: BIN_BITS];
  assign pix_unused  = ^pixel_i;
  assign frame_start = (state == ST_ARMED) && boundary;
  // The pixel on the opening boundary belongs to the new frame; the one on
  // the closing boundary is dropped.
  assign cnt_issue   = dv_i && (frame_start || (state == ST_COUNT && !boundary));

  // Forward the bin being written this edge-pair; the RAM still holds the old value.
  assign operand = (s2.vld && s2.addr == s1_addr) ? s2.data : ram_rdata;
  assign op_full = &operand;
  assign incr    = op_full ? operand : operand + CNT_WIDTH'(1);

  assign ram_we    = (state == ST_CLEAR) || s1_vld;
  assign ram_waddr = (state == ST_CLEAR) ? clr_addr : s1_addr;
  assign ram_wdata = (state == ST_CLEAR) ? '0 : incr;
  assign ram_raddr = (state == ST_DONE) ? rd_addr_i : pix_bin;

  assign req_s    = req_sync[SYNC_STAGES-1];
  assign req_rise = req_s & ~req_q;

  hist_ram #(
    .AW (BIN_BITS),
    .DW (CNT_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_nxt      = state;
    clr_addr_nxt   = clr_addr;
    armed_pend_nxt = armed_pend;
    drain_cnt_nxt  = drain_cnt;
    case (state)
      ST_CLEAR: begin
        clr_addr_nxt = clr_addr + 1'b1;
        if (arm_i) armed_pend_nxt = 1'b1;
        if (&clr_addr) begin
          state_nxt      = (armed_pend || arm_i) ? ST_ARMED : ST_IDLE;
          armed_pend_nxt = 1'b0;
        end
      end
      ST_IDLE, ST_DONE: begin
        if (arm_i) begin
          state_nxt      = ST_CLEAR;
          armed_pend_nxt = 1'b1;
          clr_addr_nxt   = '0;
        end
      end
      ST_ARMED: if (boundary) state_nxt = ST_COUNT;
      ST_COUNT: begin
        if (boundary) begin
          state_nxt     = ST_DRAIN;
          drain_cnt_nxt = 1'b0;
        end
      end
      ST_DRAIN: begin
        drain_cnt_nxt = 1'b1;
        if (drain_cnt) state_nxt = ST_DONE;
      end
      default: state_nxt = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_CLEAR;
      clr_addr   <= '0;
      armed_pend <= 1'b0;
      drain_cnt  <= 1'b0;
      vs_q       <= 1'b0;
    end else begin
      state      <= state_nxt;
      clr_addr   <= clr_addr_nxt;
      armed_pend <= armed_pend_nxt;
      drain_cnt  <= drain_cnt_nxt;
      vs_q       <= vs_n;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_vld  <= 1'b0;
      s1_addr <= '0;
      s2      <= '0;
      pix_cnt <= '0;
      sat_acc <= 1'b0;
    end else begin
      s1_vld   <= cnt_issue;
      s1_addr  <= pix_bin;
      s2.vld   <= s1_vld;
      s2.addr  <= s1_addr;
      s2.data  <= incr;
      if (frame_start) begin
        pix_cnt <= cnt_issue ? CNT_WIDTH'(1) : '0;
        sat_acc <= 1'b0;
      end else begin
        if (cnt_issue && !(&pix_cnt)) pix_cnt <= pix_cnt + CNT_WIDTH'(1);
        if (s1_vld && op_full) sat_acc <= 1'b1;
      end
    end
  end

  // Read side: synchronise the request, sample the address on its rising edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_sync     <= '0;
      req_q        <= 1'b0;
      rd_pend      <= 1'b0;
      rd_pend_done <= 1'b0;
      rd_ack_o     <= 1'b0;
      rd_data_o    <= '0;
    end else begin
      req_sync     <= {req_sync[SYNC_STAGES-2:0], rd_req_i};
      req_q        <= req_s;
      rd_pend      <= req_rise;
      rd_pend_done <= req_rise && (state == ST_DONE);
      if (rd_pend) begin
        rd_ack_o  <= 1'b1;
        rd_data_o <= rd_pend_done ? ram_rdata : '0;
      end else if (!req_s) begin
        rd_ack_o  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_o      <= 1'b1;
      done_o      <= 1'b0;
      sat_o       <= 1'b0;
      frame_pix_o <= '0;
    end else begin
      busy_o <= (state_nxt == ST_CLEAR) || (state_nxt == ST_ARMED) ||
                (state_nxt == ST_COUNT);
      done_o <= (state_nxt == ST_DONE);
      if (frame_start) begin
        sat_o       <= 1'b0;
        frame_pix_o <= '0;
      end else if (state == ST_DRAIN && drain_cnt) begin
        sat_o       <= sat_acc;
        frame_pix_o <= pix_cnt;
      end
    end
  end

endmodule

// File: tb/tb_video_histogram.sv
// Scoreboard bench: reads push expected bin values, a monitor pops them on
// each rising rd_ack_o. A second instance with 4-bit counters covers saturation.
module tb_video_histogram;

  localparam int SYNC = 2;

  logic        clk, rst;
  logic [7:0]  pixel;
  logic        dv, vs, arm, rd_req;
  logic [2:0]  rd_addr;
  logic        rd_ack, done, busy, sat;
  logic [31:0] rd_data, frame_pix;
  logic        rd_ack4, done4, busy4, sat4;
  logic [3:0]  rd_data4, frame_pix4;

  typedef struct {
    logic [2:0]  addr;
    logic [31:0] d;
    logic [3:0]  d4;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   vectors = 0;
  int   miscompares = 0;
  logic ack_q = 1'b0;

  video_histogram #(.CNT_WIDTH(32), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst), .pixel_i(pixel), .dv_i(dv), .vs_i(vs), .arm_i(arm),
    .rd_req_i(rd_req), .rd_addr_i(rd_addr), .rd_ack_o(rd_ack), .rd_data_o(rd_data),
    .done_o(done), .busy_o(busy), .sat_o(sat), .frame_pix_o(frame_pix)
  );

  video_histogram #(.CNT_WIDTH(4), .SYNC_STAGES(SYNC)) dut4 (
    .clk(clk), .rst(rst), .pixel_i(pixel), .dv_i(dv), .vs_i(vs), .arm_i(arm),
    .rd_req_i(rd_req), .rd_addr_i(rd_addr), .rd_ack_o(rd_ack4), .rd_data_o(rd_data4),
    .done_o(done4), .busy_o(busy4), .sat_o(sat4), .frame_pix_o(frame_pix4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rd_ack && !ack_q) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL sb_underflow: ack with no expected read");
      end else begin
        e = sb.pop_front();
        chk($sformatf("rd_data bin%0d", e.addr), rd_data, e.d);
        chk($sformatf("rd_data4 bin%0d", e.addr), {28'd0, rd_data4}, {28'd0, e.d4});
        chk("rd_ack4", {31'd0, rd_ack4}, 32'd1);
      end
    end
    ack_q = rd_ack;
  end

  task automatic do_read(input logic [2:0] a, input logic [31:0] exp,
                         output int lat, output int fall);
    exp_t x;
    x.addr = a;
    x.d    = exp;
    x.d4   = (exp > 32'd15) ? 4'hF : exp[3:0];
    sb.push_back(x);
    rd_addr = a;
    rd_req  = 1'b1;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!rd_ack && lat < 20);
    if (!rd_ack) begin
      vectors++; miscompares++;
      $display("FAIL read_ack_timeout: bin%0d no ack after %0d cycles", a, lat);
    end
    rd_req = 1'b0;
    fall = 0;
    do begin @(negedge clk); fall++; end while (rd_ack && fall < 20);
    if (rd_ack) begin
      vectors++; miscompares++;
      $display("FAIL read_ack_stuck: bin%0d ack high %0d cycles after release", a, fall);
    end
  endtask

  task automatic arm_pulse();
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    repeat (12) @(negedge clk);
    chk("armed_busy", {31'd0, busy}, 32'd1);
  endtask

  task automatic vs_pulse();
    dv = 1'b0;
    vs = 1'b1;
    @(negedge clk);
    vs = 1'b0;
    @(negedge clk);
  endtask

  task automatic pix(input logic [7:0] p);
    pixel = p;
    dv    = 1'b1;
    @(negedge clk);
    dv    = 1'b0;
  endtask

  task automatic end_frame();
    int n;
    vs_pulse();
    n = 0;
    while (!done && n < 20) begin @(negedge clk); n++; end
    chk("done", {31'd0, done}, 32'd1);
  endtask

  task automatic count_busy(input string nm);
    int n;
    n = 0;
    while (busy && n < 50) begin @(negedge clk); n++; end
    chk(nm, n, 32'd8);
  endtask

  initial begin
    int lat, fall;
    rst = 1'b0; pixel = '0; dv = 1'b0; vs = 1'b0; arm = 1'b0;
    rd_req = 1'b0; rd_addr = '0;
    repeat (3) @(negedge clk);
    chk("rst rd_ack", {31'd0, rd_ack}, 32'd0);
    chk("rst rd_data", rd_data, 32'd0);
    chk("rst done", {31'd0, done}, 32'd0);
    chk("rst busy", {31'd0, busy}, 32'd1);
    chk("rst sat", {31'd0, sat}, 32'd0);
    chk("rst frame_pix", frame_pix, 32'd0);
    rst = 1'b1;
    count_busy("clear_cycles");
    do_read(3'd5, 32'd0, lat, fall);

    // Mixed frame: bins 7, 0, 1.
    arm_pulse();
    vs_pulse();
    repeat (10) pix(8'hE0);
    repeat (3)  pix(8'h00);
    pix(8'h20);
    end_frame();
    chk("f1 frame_pix", frame_pix, 32'd14);
    chk("f1 sat", {31'd0, sat}, 32'd0);
    chk("f1 frame_pix4", {28'd0, frame_pix4}, 32'd14);
    do_read(3'd7, 32'd10, lat, fall);
    do_read(3'd0, 32'd3, lat, fall);
    do_read(3'd1, 32'd1, lat, fall);
    do_read(3'd2, 32'd0, lat, fall);

    // Forwarding pattern 0x40,0x40,0x60,0x40.
    arm_pulse();
    vs_pulse();
    for (int i = 0; i < 100; i++) pix((i % 4 == 2) ? 8'h60 : 8'h40);
    end_frame();
    chk("f2 frame_pix", frame_pix, 32'd100);
    chk("f2 sat", {31'd0, sat}, 32'd0);
    chk("f2 frame_pix4", {28'd0, frame_pix4}, 32'd15);
    chk("f2 sat4", {31'd0, sat4}, 32'd1);
    do_read(3'd2, 32'd75, lat, fall);
    do_read(3'd3, 32'd25, lat, fall);
    do_read(3'd7, 32'd0, lat, fall);

    // Saturation: 20 x 0xFF.
    arm_pulse();
    vs_pulse();
    repeat (20) pix(8'hFF);
    end_frame();
    chk("f3 frame_pix", frame_pix, 32'd20);
    chk("f3 sat", {31'd0, sat}, 32'd0);
    chk("f3 frame_pix4", {28'd0, frame_pix4}, 32'd15);
    chk("f3 sat4", {31'd0, sat4}, 32'd1);
    do_read(3'd7, 32'd20, lat, fall);

    // Read while counting returns 0; DONE read timing.
    arm_pulse();
    vs_pulse();
    repeat (5) pix(8'h80);
    do_read(3'd4, 32'd0, lat, fall);
    chk("count busy", {31'd0, busy}, 32'd1);
    chk("count done", {31'd0, done}, 32'd0);
    end_frame();
    chk("f4 sat4", {31'd0, sat4}, 32'd0);
    do_read(3'd4, 32'd5, lat, fall);
    chk("read_latency", lat, SYNC + 2);
    chk("ack_fall_latency", fall, SYNC + 1);

    // Reset mid-frame, then a clean frame.
    arm_pulse();
    vs_pulse();
    repeat (7) pix(8'hA0);
    rst = 1'b0;
    @(negedge clk);
    chk("mid rst rd_ack", {31'd0, rd_ack}, 32'd0);
    chk("mid rst rd_data", rd_data, 32'd0);
    chk("mid rst done", {31'd0, done}, 32'd0);
    chk("mid rst busy", {31'd0, busy}, 32'd1);
    chk("mid rst sat", {31'd0, sat}, 32'd0);
    chk("mid rst frame_pix", frame_pix, 32'd0);
    rst = 1'b1;
    count_busy("reclear_cycles");
    arm_pulse();
    vs_pulse();
    repeat (3) pix(8'hA0);
    repeat (2) pix(8'hC0);
    end_frame();
    chk("f5 frame_pix", frame_pix, 32'd5);
    do_read(3'd5, 32'd3, lat, fall);
    do_read(3'd6, 32'd2, lat, fall);

    repeat (5) @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
